// File: rtl/seq_mult_unit.sv
// Sequential WIDTH x WIDTH unsigned shift-add multiplier feeding the Hi/Lo unit via MulAns/op_out/done.
// Optional early termination on a drained multiplier: define SEQ_MULT_EARLY_TERM_EN.
module seq_mult_unit #(
  parameter int          WIDTH = 32,
  parameter logic [5:0]  MULTU = 6'd1,
  parameter logic [5:0]  MADDU = 6'd28
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [5:0]           op,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   MulAns,
  output logic [5:0]           op_out
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state, stateNext;
  logic [WIDTH-1:0]     mcand, mplier;
  logic [2*WIDTH-1:0]   acc, accStep, accFinal;
  logic [CNT_W-1:0]     cnt;
  logic [5:0]           opReg;
  logic                 opValid, lastStep;

  // One multiply step: conditional add into the upper half, then shift {carry,acc} right by one.
  function automatic logic [2*WIDTH-1:0] shiftAddStep(
    input logic [2*WIDTH-1:0] accIn,
    input logic [WIDTH-1:0]   addend,
    input logic               addEn
  );
    logic [WIDTH:0] upper;
    upper = {1'b0, accIn[2*WIDTH-1:WIDTH]} + (addEn ? {1'b0, addend} : {(WIDTH+1){1'b0}});
    return {upper, accIn[WIDTH-1:1]};
  endfunction

  assign opValid = (op == MULTU) || (op == MADDU);
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);

  always_comb begin
    accStep = shiftAddStep(acc, mcand, mplier[0]);
`ifdef SEQ_MULT_EARLY_TERM_EN
    // Once no multiplier bits remain, skip the remaining pure shifts in one go.
    lastStep = (cnt == CNT_W'(WIDTH - 1)) || (mplier[WIDTH-1:1] == '0);
    accFinal = accStep >> (CNT_W'(WIDTH - 1) - cnt);
`else
    lastStep = (cnt == CNT_W'(WIDTH - 1));
    accFinal = accStep;
`endif
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (start && opValid) stateNext = CALC;
      CALC:    if (lastStep) stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= stateNext;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      opReg  <= '0;
      MulAns <= '0;
      op_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && opValid) begin
            mcand  <= a;
            mplier <= b;
            opReg  <= op;
            acc    <= '0;
            cnt    <= '0;
          end
        end
        CALC: begin
          acc    <= accStep;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          // Outputs only move here, so downstream can sample them at any time.
          if (lastStep) begin
            MulAns <= accFinal;
            op_out <= opReg;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/seq_mult_unit.md
Name: seq_mult_unit

Overview:
- Sequential 32x32 unsigned shift-add multiplier that produces the 64-bit product consumed by the Hi/Lo accumulator register.
- It is the producer side of the MulAns interface:
  - accepts operands plus opcode (MULTU or MADDU) from decode/execute;
  - computes the product over multiple cycles;
  - presents the product with the opcode and a one-cycle done strobe, so Hi/Lo either loads it (MULTU) or accumulates it (MADDU).

Parameters:
- WIDTH, 32: operand width; product is 2*WIDTH bits.
- MULTU, 6'd1: opcode for multiply-and-load.
- MADDU, 6'd28: opcode for multiply-and-accumulate.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request strobe; sampled only in IDLE.
- op  input  6  opcode presented with start.
- a  input  WIDTH  multiplicand.
- b  input  WIDTH  multiplier.
- busy  output  1  high in CALC and DONE.
- done  output  1  one-cycle pulse; product and op_out are valid.
- MulAns  output  2*WIDTH  product; held stable between done pulses.
- op_out  output  6  opcode latched at start; held with MulAns.

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE; busy=0, done=0, MulAns=0, op_out=0.
  - Internal accumulator, multiplier shadow and counter cleared.
  - Reset mid-operation aborts the operation; no done is issued.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - If start=1 and op is MULTU or MADDU at edge T:
    - latch a into mcand, b into mplier, op into op_reg;
    - acc=0, cnt=0; go to CALC.
  - start with any other op: ignored, stay IDLE, busy stays 0.
- CALC, one step per edge:
  - If mplier[0]=1, acc[2W-1:W] += mcand, carry kept as the (W+1)th bit.
  - Then {carry,acc} shifts right 1; mplier shifts right 1; cnt += 1.
  - When cnt reaches WIDTH-1 on an edge, that edge is the last step.
  - At the last step: go to DONE, load MulAns with the final acc, load op_out with op_reg.
  - With WIDTH=32, the last step is edge T+32.
- DONE:
  - done=1 for exactly one cycle; next edge returns to IDLE; busy drops with it.
  - Earliest next accepted start is at edge T+34 (start is only sampled in IDLE).
- start asserted during CALC/DONE: ignored, not queued; operands and op are not re-latched.
- Arithmetic:
  - Unsigned only; no overflow is possible.
  - MulAns = a*b exactly, modulo nothing.
- Holding rule:
  - MulAns and op_out change only on the edge entering DONE (or on reset).
  - The downstream register may sample at any time; new values are flagged only by done.
- Counter width: ceil(log2(WIDTH))+1 bits.
- Inputs a, b, op may change freely after the start edge.

Optional Feature:
- Macro: SEQ_MULT_EARLY_TERM_EN.
- Defined: CALC also terminates when the shifted multiplier is zero after a step.
  - acc is then aligned by shifting right by the remaining (WIDTH-1-cnt) positions in the same edge before MulAns is loaded.
  - Latency is 1 + index of the highest set bit of b; b=0 finishes after 1 CALC step.
  - done/busy timing rules are otherwise unchanged.
- Not defined: fixed WIDTH-cycle CALC regardless of operands.

Test Plan:
- a=3, b=5, op=MULTU, start at T -> done=1 in cycle after edge T+32; MulAns=64'd15, op_out=6'd1; busy high T+1..T+33.
- a=32'hFFFFFFFF, b=32'hFFFFFFFF, op=MADDU -> MulAns=64'hFFFFFFFE00000001, op_out=6'd28, single done pulse.
- Start a=2, b=2, then at T+10 start again with a=9, b=9 -> second start ignored; MulAns=4; no second done until a new start in IDLE.
- Start a=100, b=100; drop rst at T+15 -> busy=0, done=0, MulAns=0 immediately; no done follows; next op 6*7 gives 42.
- start with op=6'd5 -> busy stays 0, no done, MulAns unchanged from prior value.
- With SEQ_MULT_EARLY_TERM_EN:
  - a=7, b=1 -> done after 1 CALC step, MulAns=7.
  - a=7, b=32'h80000000 -> full 32 steps, MulAns=64'h380000000.
